mux_scan_sequencer: RTL and testbench

- Drives the 2-bit select lines of the 4:1 multiplexer stage.
- Steps the select through the enabled input channels, holding each channel for a programmable dwell time.
- Issues a one-cycle sample strobe on the last cycle of each dwell, so the downstream capture logic latches Y while the select is stable.
- Supports one-shot sweeps and continuous scanning.

---
 rtl/mux_scan_if.sv | 31 +++
 rtl/mux_scan_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Handshake and status bundle between a scan controller and the mux scan sequencer.
// The controller side drives the scan request and configuration. The sequencer
// side drives the mux select and the status strobes.
interface mux_scan_if #(
    parameter int DWELL_W = 8
);
    // Request and configuration, driven by the controller
    logic               start;
    logic               stop;
    logic               mode;
    logic [3:0]         ch_en;
    logic [DWELL_W-1:0] dwell;

    // Select and status, driven by the sequencer
    logic [1:0]         S;
    logic               sample;
    logic               busy;
    logic               done;
    logic               err;
    logic [7:0]         sweeps;

    modport master (
        output start, stop, mode, ch_en, dwell,
        input  S, sample, busy, done, err, sweeps
    );

    modport slave (
        input  start, stop, mode, ch_en, dwell,
        output S, sample, busy, done, err, sweeps
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps the 2-bit select of a 4:1 mux through the enabled
// channels, holding each one for dwell_eff cycles. It raises sample on the last
// cycle of each dwell so downstream capture latches Y while S is stable.
// It supports one-shot sweeps and continuous scanning with a sticky stop request.
module mux_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    mux_scan_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic               sample_q, sample_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         sweeps_q, sweeps_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic [3:0]         ch_en_q, ch_en_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [DWELL_W-1:0] dwell_in_eff;
    logic               stop_seen;
    logic               end_of_dwell;
    logic               wrap;

    // Lowest set bit of the mask. A zero mask returns 0 and is never used.
    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_idx = 2'(i);
        end
    endfunction

    // Highest set bit of the mask, used to detect the end of a sweep.
    function automatic logic [1:0] highest_idx(input logic [3:0] mask);
        highest_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) highest_idx = 2'(i);
        end
    endfunction

    // Next enabled index above cur. If none is enabled above cur, wrap to the lowest.
    function automatic logic [1:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
        next_idx = lowest_idx(mask);
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (2'(i) > cur)) next_idx = 2'(i);
        end
    endfunction

    // Next-state logic. Strobes are computed one cycle ahead so that the
    // registered sample and done line up with the last dwell cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        s_d          = s_q;
        sample_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        sweeps_d     = sweeps_q;
        cnt_d        = cnt_q;
        stop_d       = stop_q;
        ch_en_d      = ch_en_q;
        mode_d       = mode_q;
        dwell_d      = dwell_q;
        wrap         = 1'b0;
        dwell_in_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        stop_seen    = stop_q | bus.stop;
        end_of_dwell = (cnt_q == dwell_q);

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                stop_d = 1'b0;
                if (bus.start) begin
                    if (bus.ch_en == 4'b0000) begin
                        err_d = 1'b1;
                    end else begin
                        ch_en_d  = bus.ch_en;
                        mode_d   = bus.mode;
                        dwell_d  = dwell_in_eff;
                        sweeps_d = 8'd0;
                        s_d      = lowest_idx(bus.ch_en);
                        cnt_d    = DWELL_W'(1);
                        busy_d   = 1'b1;
                        state_d  = SCAN;
                        sample_d = (dwell_in_eff == DWELL_W'(1));
                        done_d   = sample_d && !bus.mode &&
                                   (lowest_idx(bus.ch_en) == highest_idx(bus.ch_en));
                    end
                end
            end

            SCAN: begin
                if (bus.stop) stop_d = 1'b1;
                if (end_of_dwell) begin
                    // The sample fires in this cycle, so the channel is done at this edge.
                    wrap = (s_q == highest_idx(ch_en_q));
                    if (wrap) sweeps_d = sweeps_q + 8'd1;
                    if (stop_seen || (wrap && !mode_q)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        stop_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        s_d      = next_idx(ch_en_q, s_q);
                        cnt_d    = DWELL_W'(1);
                        sample_d = (dwell_q == DWELL_W'(1));
                        done_d   = sample_d && !mode_q &&
                                   (next_idx(ch_en_q, s_q) == highest_idx(ch_en_q));
                    end
                end else begin
                    cnt_d    = cnt_q + DWELL_W'(1);
                    sample_d = ((cnt_q + DWELL_W'(1)) == dwell_q);
                    done_d   = sample_d && !mode_q && (s_q == highest_idx(ch_en_q));
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all control and output registers are reset, including the latched configuration, so the outputs are defined immediately after reset.
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= 2'd0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sweeps_q <= 8'd0;
            cnt_q    <= '0;
            stop_q   <= 1'b0;
            ch_en_q  <= 4'b0000;
            mode_q   <= 1'b0;
            dwell_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its _d value from before the edge.
            state_q  <= state_d;
            s_q      <= s_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sweeps_q <= sweeps_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            ch_en_q  <= ch_en_d;
            mode_q   <= mode_d;
            dwell_q  <= dwell_d;
        end
    end

    assign bus.S      = s_q;
    assign bus.sample = sample_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.sweeps = sweeps_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed testbench for mux_scan_sequencer. Inputs are driven 1 time unit
// after each rising edge, and outputs are checked at that same point.
module tb_mux_scan_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux_scan_if #(.DWELL_W(8)) bus ();

    mux_scan_sequencer #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.ch_en = 4'b0000;
        bus.dwell = 8'd0;

        // Reset state
        #3;
        check("rst_S", 32'(bus.S), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sample", 32'(bus.sample), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_sweeps", 32'(bus.sweeps), 0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 0);

        // One-shot sweep over all four channels with dwell 3. The config is changed mid-scan and must be ignored.
        bus.mode  = 1'b0;
        bus.ch_en = 4'b1111;
        bus.dwell = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ch_en = 4'b0001;
        bus.dwell = 8'd7;
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("os_S_%0d", k), 32'(bus.S), 32'((k - 1) / 3));
            check($sformatf("os_sample_%0d", k), 32'(bus.sample), 32'(k % 3 == 0));
            check($sformatf("os_done_%0d", k), 32'(bus.done), 32'(k == 12));
            check($sformatf("os_busy_%0d", k), 32'(bus.busy), 1);
            tick();
        end
        check("os_end_busy", 32'(bus.busy), 0);
        check("os_end_S", 32'(bus.S), 3);
        check("os_end_done", 32'(bus.done), 0);
        check("os_end_sample", 32'(bus.sample), 0);
        check("os_end_sweeps", 32'(bus.sweeps), 1);

        // Continuous scan over channels 1 and 3 with dwell 1. The sweep counter wraps 255 -> 0.
        bus.mode  = 1'b1;
        bus.ch_en = 4'b1010;
        bus.dwell = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 521; k++) begin
            check($sformatf("cont_S_%0d", k), 32'(bus.S), (k % 2 == 1) ? 1 : 3);
            check($sformatf("cont_sample_%0d", k), 32'(bus.sample), 1);
            check($sformatf("cont_sweeps_%0d", k), 32'(bus.sweeps), 32'(((k - 1) / 2) % 256));
            if (k == 521) bus.stop = 1'b1;
            tick();
        end
        bus.stop = 1'b0;
        check("cont_stop_busy", 32'(bus.busy), 0);
        check("cont_stop_S", 32'(bus.S), 1);
        check("cont_stop_done", 32'(bus.done), 0);
        check("cont_stop_sweeps", 32'(bus.sweeps), 4);

        // Start with an empty mask raises err for one cycle and changes nothing else.
        bus.ch_en = 4'b0000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("err_err", 32'(bus.err), 1);
        check("err_busy", 32'(bus.busy), 0);
        check("err_S", 32'(bus.S), 1);
        check("err_sample", 32'(bus.sample), 0);
        check("err_sweeps", 32'(bus.sweeps), 4);
        tick();
        check("err_clear", 32'(bus.err), 0);
        check("err_busy2", 32'(bus.busy), 0);

        // Continuous scan over channels 0..2 with dwell 4. A stop pulse in the 2nd cycle of channel 1 lets channel 1 finish.
        bus.mode  = 1'b1;
        bus.ch_en = 4'b0111;
        bus.dwell = 8'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("stop_S_%0d", k), 32'(bus.S), (k <= 4) ? 0 : 1);
            check($sformatf("stop_sample_%0d", k), 32'(bus.sample), 32'(k == 4 || k == 8));
            check($sformatf("stop_busy_%0d", k), 32'(bus.busy), 1);
            check($sformatf("stop_done_%0d", k), 32'(bus.done), 0);
            if (k == 6) bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
        end
        check("stop_end_busy", 32'(bus.busy), 0);
        check("stop_end_S", 32'(bus.S), 1);
        check("stop_end_done", 32'(bus.done), 0);
        check("stop_end_sample", 32'(bus.sample), 0);
        check("stop_end_sweeps", 32'(bus.sweeps), 0);
        tick();
        check("stop_idle_busy", 32'(bus.busy), 0);
        check("stop_idle_S", 32'(bus.S), 1);

        // A dwell of 0 behaves as 1. One-shot on channel 2 only: sample and done come in the same cycle.
        bus.mode  = 1'b0;
        bus.ch_en = 4'b0100;
        bus.dwell = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("d0_S", 32'(bus.S), 2);
        check("d0_sample", 32'(bus.sample), 1);
        check("d0_done", 32'(bus.done), 1);
        check("d0_busy", 32'(bus.busy), 1);
        check("d0_sweeps", 32'(bus.sweeps), 0);
        tick();
        check("d0_end_busy", 32'(bus.busy), 0);
        check("d0_end_S", 32'(bus.S), 2);
        check("d0_end_done", 32'(bus.done), 0);
        check("d0_end_sample", 32'(bus.sample), 0);
        check("d0_end_sweeps", 32'(bus.sweeps), 1);

        // Reset asserted mid-scan clears the outputs at once, with no clock edge.
        bus.mode  = 1'b1;
        bus.ch_en = 4'b0100;
        bus.dwell = 8'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("rm_S_%0d", k), 32'(bus.S), 2);
            check($sformatf("rm_busy_%0d", k), 32'(bus.busy), 1);
            check($sformatf("rm_sample_%0d", k), 32'(bus.sample), 32'(k == 5));
            if (k < 7) tick();
        end
        check("rm_sweeps_pre", 32'(bus.sweeps), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rm_S", 32'(bus.S), 0);
        check("rm_busy", 32'(bus.busy), 0);
        check("rm_sweeps", 32'(bus.sweeps), 0);
        check("rm_sample", 32'(bus.sample), 0);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rm_after_busy_%0d", k), 32'(bus.busy), 0);
            check($sformatf("rm_after_S_%0d", k), 32'(bus.S), 0);
            check($sformatf("rm_after_sample_%0d", k), 32'(bus.sample), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
